// File: rtl/display_source_arbiter_if.sv
// Source/display bundle for display_source_arbiter: three time sources and
// level requests in, one-hot grant and the selected display word out.
interface display_source_arbiter_if;
  logic [38:0] src0_number;
  logic [7:0]  src0_points;
  logic [38:0] src1_number;
  logic [7:0]  src1_points;
  logic [38:0] src2_number;
  logic [7:0]  src2_points;
  logic [2:0]  req;
  logic [2:0]  gnt;
  logic [1:0]  active_src;
  logic [38:0] disp_number;
  logic [7:0]  disp_points;
  logic        disp_blank;

  modport master (
    output src0_number, src0_points, src1_number, src1_points,
           src2_number, src2_points, req,
    input  gnt, active_src, disp_number, disp_points, disp_blank
  );

  modport slave (
    input  src0_number, src0_points, src1_number, src1_points,
           src2_number, src2_points, req,
    output gnt, active_src, disp_number, disp_points, disp_blank
  );
endinterface

// File: rtl/display_source_arbiter.sv
// Arbitrates the 8-digit display between stopwatch, lap recall and alarm, with
// minimum hold and blank gap. Optional src2 flashing under `define DISP_FLASH_EN.
module display_source_arbiter #(
  parameter int CLK_PER_MS = 100000,
  parameter int HOLD_MS    = 2000,
  parameter int BLANK_MS   = 50,
  parameter int FLASH_MS   = 250
) (
  input  logic                     clock,
  input  logic                     reset_n,
  display_source_arbiter_if.slave  bus
);

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

  typedef enum logic {OWN, GAP} state_t;

  state_t       state;
  logic [PW-1:0] prescaler;
  logic          ms_tick;
  logic [1:0]    owner, target, cand, show_idx, grant_idx;
  logic [15:0]   hold_cnt, gap_cnt;
  logic          hold_done, owner_req, do_switch;
  logic          grant_now, going_gap, blank_now, own_blank;
  logic [38:0]   sel_number;
  logic [7:0]    sel_points;

  assign ms_tick   = (prescaler == PW'(CLK_PER_MS - 1));
  assign hold_done = (hold_cnt == 16'(HOLD_MS));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cand = 2'd0;
    if (bus.req[2])      cand = 2'd2;
    else if (bus.req[1]) cand = 2'd1;

    owner_req = 1'b0;
    case (owner)
      2'd1:    owner_req = bus.req[1];
      2'd2:    owner_req = bus.req[2];
      default: owner_req = 1'b1;
    endcase

    do_switch = (cand != owner) && ((cand > owner) || (!owner_req && hold_done));

    grant_now = 1'b0;
    grant_idx = owner;
    going_gap = 1'b0;
    if (state == OWN) begin
      if (do_switch) begin
        if (BLANK_MS == 0) begin
          grant_now = 1'b1;
          grant_idx = cand;
        end else begin
          going_gap = 1'b1;
        end
      end
    end else if (ms_tick && gap_cnt == 16'(BLANK_MS - 1)) begin
      grant_now = 1'b1;
      grant_idx = target;
    end

    blank_now = going_gap || (state == GAP && !grant_now);
    show_idx  = grant_now ? grant_idx : owner;

    sel_number = bus.src0_number;
    sel_points = bus.src0_points;
    case (show_idx)
      2'd1: begin sel_number = bus.src1_number; sel_points = bus.src1_points; end
      2'd2: begin sel_number = bus.src2_number; sel_points = bus.src2_points; end
      default: ;
    endcase
  end

`ifdef DISP_FLASH_EN
  logic [15:0] flash_cnt;
  logic        flash_phase, flash_wrap;

  // Phase restarts on every grant, so a fresh src2 grant always opens lit.
  assign flash_wrap = (state == OWN) && (owner == 2'd2) && ms_tick &&
                      (flash_cnt == 16'(FLASH_MS - 1));
  assign own_blank  = !grant_now && (owner == 2'd2) && (flash_phase ^ flash_wrap);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flash_cnt   <= '0;
      flash_phase <= 1'b0;
    end else if (grant_now) begin
      flash_cnt   <= '0;
      flash_phase <= 1'b0;
    end else if (state == OWN && owner == 2'd2 && ms_tick) begin
      flash_cnt   <= flash_wrap ? 16'd0 : flash_cnt + 16'd1;
      flash_phase <= flash_phase ^ flash_wrap;
    end
  end
`else
  assign own_blank = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= OWN;
      prescaler       <= '0;
      owner           <= 2'd0;
      target          <= 2'd0;
      hold_cnt        <= '0;
      gap_cnt         <= '0;
      bus.gnt         <= 3'b001;
      bus.active_src  <= 2'd0;
      bus.disp_number <= '0;
      bus.disp_points <= '0;
      bus.disp_blank  <= 1'b0;
    end else begin
      prescaler <= ms_tick ? '0 : prescaler + PW'(1);

      case (state)
        OWN: begin
          if (do_switch) begin
            target         <= cand;
            bus.active_src <= cand;
            if (BLANK_MS == 0) begin
              owner    <= cand;
              hold_cnt <= '0;
            end else begin
              state   <= GAP;
              gap_cnt <= '0;
            end
          end else if (ms_tick && !hold_done) begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end
        GAP: begin
          // Target stays latched for the whole gap; requests are re-read in OWN.
          if (grant_now) begin
            state    <= OWN;
            owner    <= target;
            hold_cnt <= '0;
          end else if (ms_tick) begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        default: state <= OWN;
      endcase

      if (blank_now) begin
        bus.gnt         <= 3'b000;
        bus.disp_number <= '0;
        bus.disp_points <= '0;
        bus.disp_blank  <= 1'b1;
      end else begin
        bus.gnt         <= 3'b001 << show_idx;
        bus.disp_number <= sel_number;
        bus.disp_points <= sel_points;
        bus.disp_blank  <= own_blank;
      end
    end
  end

endmodule

// File: doc/display_source_arbiter.md
Name: display_source_arbiter

Overview:
- Shares the single 8-digit seven-segment display path between three time/message sources: live stopwatch (src0, default owner), lap recall (src1) and alarm/message (src2).
- Sits directly upstream of the display driver.
- Selects which 39-bit time word and 8-bit decimal-point mask drive the display.
- Enforces a minimum on-screen hold per grant, and inserts a blank gap between owner changes so a stale value is never shown.

Parameters:
- CLK_PER_MS, 100000: system clocks per 1 ms tick (100 MHz board clock).
- HOLD_MS, 2000: minimum ms a granted src1/src2 owns the display. Range 1..65535.
- BLANK_MS, 50: ms of blanked display between owners. 0 means switch directly with no gap.
- FLASH_MS, 250: half-period of flash in ms (optional feature only).

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- src0_number  in  39  stopwatch time, 10 ns units.
- src0_points  in  8  stopwatch decimal-point mask.
- src1_number  in  39  lap-recall time.
- src1_points  in  8  lap-recall decimal points.
- src2_number  in  39  alarm/message value.
- src2_points  in  8  alarm/message decimal points.
- req  in  3  level requests; req[0] ignored (src0 implicitly always requests).
- gnt  out  3  one-hot grant; 000 during gap.
- active_src  out  2  current or pending owner index.
- disp_number  out  39  to display driver.
- disp_points  out  8  to display driver.
- disp_blank  out  1  1 means the driver shows all digits off.

Behaviour:
- Reset (async, immediate, also mid-operation): state OWN, owner=0, gnt=001, active_src=0, disp_number=0, disp_points=0, disp_blank=0, hold count=0, prescaler=0, gap count=0.
- Prescaler counts 0..CLK_PER_MS-1. ms_tick is a 1-clock pulse on wrap to 0.
- All outputs are registered. Latency from srcN_number/points to disp_* is 1 clock while N owns.
- Candidate each clock: 2 if req[2]; else 1 if req[1]; else 0.
- Hold count: reset to 0 on grant, +1 per ms_tick, saturates at HOLD_MS. hold_done = (count == HOLD_MS). Owner 0 has no hold.
- State OWN (owner k): disp_* follow src k, gnt = one-hot(k), disp_blank=0.
  - Switch request when candidate != k AND either:
    - candidate > k (preemption; src2 preempts src1, either preempts src0), or
    - req[k]=0 AND hold_done (k=1 or 2).
  - On switch: latch target=candidate, active_src=target.
    - BLANK_MS>0: go to GAP.
    - BLANK_MS=0: owner=target next clock, hold reset.
- req[k] dropped before hold_done: owner keeps the display until hold_done, then releases to the candidate (0 if none).
- req[k] held indefinitely: owner never times out. Only preemption by a higher index ends it.
- State GAP:
  - gnt=000, disp_blank=1, disp_number=0, disp_points=0.
  - Counts BLANK_MS ms_ticks, then owner=target, gnt=one-hot(target), hold count=0, state OWN.
  - Target is latched: request changes during GAP are ignored; evaluation resumes in OWN.
  - A dropped target still receives a full HOLD_MS.
- Simultaneous req[1] and req[2] rise: src2 wins.
- req[2] rising in the same clock that src1's hold completes: src2 wins (candidate rule).
- gnt is always one-hot or 000, never multi-hot. active_src never holds 3.

Optional Feature:
- Macro DISP_FLASH_EN.
- When defined: while src2 owns in OWN, disp_blank toggles every FLASH_MS ms_ticks, starting at 0 on grant. Grant, hold and arbitration logic are unchanged. Flash phase counter resets on every grant.
- When undefined: disp_blank=1 only in GAP, and no flash counter is built.

Test Plan:
All scenarios use CLK_PER_MS=4, HOLD_MS=3, BLANK_MS=1, FLASH_MS=2.
- Reset, no req; src0_number=39'h123 -> gnt=001, active_src=0, disp_number=39'h123 one clock after input, disp_blank=0.
- req[1] pulsed 1 clock -> next clock gnt=000 and disp_blank=1 for 1 ms (4 clocks ±3 for tick phase); then gnt=010 showing src1 for ≥3 ticks; then 1-tick gap and back to gnt=001.
- src1 owns with req[1] held; raise req[2] -> immediate gap, then gnt=100. Drop req[2] after hold_done with req[1] still high -> gap, then gnt=010.
- req[1] and req[2] rise in the same clock -> active_src=2, gnt=100 after gap; gnt never multi-hot (assertion).
- Assert reset_n=0 mid-GAP, asynchronously between edges -> outputs immediately return to reset values, gnt=001, disp_blank=0.
- With DISP_FLASH_EN, src2 owning -> disp_blank toggles every 2 ms_ticks (0,0,1,1,...); without the macro -> disp_blank stays 0 while src2 owns.
